// File: rtl/sdr_audio_pkg.sv
// Shared widths, AGC state encoding and saturation limits for the SSB audio chain.
package sdr_audio_pkg;

    localparam int SAMPLE_W  = 12;
    localparam int MAG_W     = SAMPLE_W + 1;
    localparam int GAIN_W    = 12;
    localparam int GAIN_FRAC = 8;
    localparam int PROD_W    = SAMPLE_W + GAIN_W + 1;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 12'sh7FF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 12'sh800;

    typedef enum logic [1:0] {
        AGC_IDLE   = 2'd0,
        AGC_ATTACK = 2'd1,
        AGC_HOLD   = 2'd2,
        AGC_DECAY  = 2'd3
    } agc_state_t;

    // One extra bit so that |-2048| = 2048 is representable.
    function automatic logic [MAG_W-1:0] sample_mag(input logic signed [SAMPLE_W-1:0] s);
        logic signed [MAG_W-1:0] e;
        e = {s[SAMPLE_W-1], s};
        return e[MAG_W-1] ? -e : e;
    endfunction

endpackage

// File: rtl/sat_mul_q8.sv
// Signed sample x unsigned Q4.8 gain, shift by 8, saturate to 12 bits with clip flag.
// Latency: 2 cycles (product register, saturate register); valid bit advances every cycle.
// Backpressure: none; a new sample may be accepted every cycle.
module sat_mul_q8
    import sdr_audio_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [GAIN_W-1:0]   gain,
    output logic                       out_vld,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic                       clip
);

    localparam logic signed [PROD_W-1:0] MAX_EXT = PROD_W'(SAT_MAX);
    localparam logic signed [PROD_W-1:0] MIN_EXT = PROD_W'(SAT_MIN);

    logic signed [PROD_W-1:0]   prod_c;
    logic signed [PROD_W-1:0]   prod_q;
    logic signed [PROD_W-1:0]   scaled;
    logic                       prod_vld;
    logic signed [SAMPLE_W-1:0] sat_sample;
    logic                       sat_hit;

    assign prod_c = PROD_W'(sample) * $signed(PROD_W'({1'b0, gain}));
    assign scaled = prod_q >>> GAIN_FRAC;

    always_comb begin
        sat_sample = scaled[SAMPLE_W-1:0];
        sat_hit    = 1'b0;
        if (scaled > MAX_EXT) begin
            sat_sample = SAT_MAX;
            sat_hit    = 1'b1;
        end else if (scaled < MIN_EXT) begin
            sat_sample = SAT_MIN;
            sat_hit    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_vld   <= 1'b0;
            prod_q     <= '0;
            out_vld    <= 1'b0;
            out_sample <= '0;
            clip       <= 1'b0;
        end else begin
            prod_vld <= in_vld;
            out_vld  <= prod_vld;
            clip     <= prod_vld & sat_hit;
            if (in_vld)
                prod_q <= prod_c;
            if (prod_vld)
                out_sample <= sat_sample;
        end
    end

endmodule

// File: rtl/ssb_agc.sv
// Peak-driven attack/hold/decay audio AGC behind the SSB demodulator.
// Latency: 3 cycles data_valid -> audio_valid; gain updates one cycle after audio_valid.
// Backpressure: none; accepts samples back-to-back or with arbitrary gaps.
module ssb_agc
    import sdr_audio_pkg::*;
#(
    parameter int GAIN_INIT     = 256,
    parameter int GAIN_MIN      = 16,
    parameter int GAIN_MAX      = 4095,
    parameter int TARGET_HI     = 1536,
    parameter int TARGET_LO     = 768,
    parameter int ATTACK_SHIFT  = 3,
    parameter int HOLD_SAMPLES  = 2048,
    parameter int DECAY_SAMPLES = 64
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] data_in,
    input  logic                       data_valid,
    output logic signed [SAMPLE_W-1:0] audio_out,
    output logic                       audio_valid,
    output logic        [GAIN_W-1:0]   gain,
    output logic                       clip,
    output logic        [1:0]          agc_state
);

    localparam int HOLD_W  = $clog2(HOLD_SAMPLES + 1);
    localparam int DECAY_W = $clog2(DECAY_SAMPLES + 1);

    localparam logic [GAIN_W-1:0]  G_INIT  = GAIN_W'(GAIN_INIT);
    localparam logic [GAIN_W-1:0]  G_MIN   = GAIN_W'(GAIN_MIN);
    localparam logic [GAIN_W-1:0]  G_MAX   = GAIN_W'(GAIN_MAX);
    localparam logic [MAG_W-1:0]   T_HI    = MAG_W'(TARGET_HI);
    localparam logic [MAG_W-1:0]   T_LO    = MAG_W'(TARGET_LO);
    localparam logic [HOLD_W-1:0]  HOLD_LD = HOLD_W'(HOLD_SAMPLES);
    localparam logic [DECAY_W-1:0] DEC_LD  = DECAY_W'(DECAY_SAMPLES);

    logic signed [SAMPLE_W-1:0] s1_data;
    logic                       s1_vld;

    agc_state_t         state_q, state_d;
    logic [GAIN_W-1:0]  gain_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DECAY_W-1:0] decay_q, decay_d;

    logic [MAG_W-1:0]   peak;
    logic [GAIN_W-1:0]  step;
    logic [GAIN_W:0]    gain_sub;
    logic [GAIN_W-1:0]  gain_dec;
    logic [GAIN_W-1:0]  gain_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= data_valid;
            if (data_valid)
                s1_data <= data_in;
        end
    end

    sat_mul_q8 u_mul (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (s1_vld),
        .sample     (s1_data),
        .gain       (gain),
        .out_vld    (audio_valid),
        .out_sample (audio_out),
        .clip       (clip)
    );

    assign peak      = sample_mag(audio_out);
    assign gain_sub  = {1'b0, gain} - {1'b0, step};
    assign gain_inc  = gain + GAIN_W'(1);
    assign agc_state = state_q;

    // Attack step never collapses to zero, and the subtraction is floored at GAIN_MIN.
    always_comb begin
        step = gain >> ATTACK_SHIFT;
        if (step == '0)
            step = GAIN_W'(1);
        gain_dec = gain_sub[GAIN_W-1:0];
        if (gain_sub[GAIN_W] || (gain_sub[GAIN_W-1:0] < G_MIN))
            gain_dec = G_MIN;
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain;
        hold_d  = hold_q;
        decay_d = decay_q;
        if (audio_valid) begin
            if (peak > T_HI) begin
                gain_d  = gain_dec;
                hold_d  = HOLD_LD;
                state_d = AGC_ATTACK;
            end else begin
                case (state_q)
                    AGC_ATTACK: state_d = AGC_HOLD;
                    AGC_HOLD: begin
                        hold_d = hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) begin
                            state_d = AGC_DECAY;
                            decay_d = DEC_LD;
                        end
                    end
                    AGC_DECAY: begin
                        decay_d = decay_q - DECAY_W'(1);
                        if (decay_q == DECAY_W'(1)) begin
                            decay_d = DEC_LD;
                            if ((peak < T_LO) && (gain < G_MAX)) begin
                                gain_d = gain_inc;
                                if (gain_inc == G_MAX)
                                    state_d = AGC_IDLE;
                            end
                        end
                    end
                    default: begin
                        if (peak < T_LO) begin
                            state_d = AGC_DECAY;
                            decay_d = DEC_LD;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= AGC_IDLE;
            gain    <= G_INIT;
            hold_q  <= '0;
            decay_q <= '0;
        end else begin
            state_q <= state_d;
            gain    <= gain_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
        end
    end

endmodule

// File: tb/tb_ssb_agc.sv
// Directed bench for ssb_agc: pass-through, attack/hold/decay, saturation, valid timing, reset.
module tb_ssb_agc;

    logic               clk        = 1'b0;
    logic               rst        = 1'b0;
    logic signed [11:0] data_in    = '0;
    logic               data_valid = 1'b0;
    logic               hi_valid   = 1'b0;

    logic signed [11:0] audio_out, hi_out;
    logic               audio_valid, hi_audio_valid;
    logic               clip, hi_clip;
    logic [11:0]        gain, hi_gain;
    logic [1:0]         agc_state, hi_state;

    int errors = 0;
    int checks = 0;
    int out_cnt;

    always #5 clk = ~clk;

    ssb_agc u_dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .gain        (gain),
        .clip        (clip),
        .agc_state   (agc_state)
    );

    // Starts near the ceiling with a short decay interval so saturation is reachable quickly.
    ssb_agc #(.GAIN_INIT(4093), .DECAY_SAMPLES(4)) u_hi (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (hi_valid),
        .audio_out   (hi_out),
        .audio_valid (hi_audio_valid),
        .gain        (hi_gain),
        .clip        (hi_clip),
        .agc_state   (hi_state)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one sample and returns at the mid-point of its audio_valid cycle.
    task automatic push(input logic signed [11:0] x, input bit hi);
        @(negedge clk);
        data_in = x;
        if (hi) hi_valid = 1'b1; else data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        hi_valid   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Back-to-back samples, then drains so the last control update is visible.
    task automatic stream(input int n, input logic signed [11:0] x, input bit hi);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_in = x;
            if (hi) hi_valid = 1'b1; else data_valid = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
        hi_valid   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic bit pat(input int i);
        return (i < 10) || ((i < 40) && (i % 5 == 0));
    endfunction

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_out",   audio_out,   0);
        chk("rst_vld",   audio_valid, 0);
        chk("rst_clip",  clip,        0);
        chk("rst_gain",  gain,        256);
        chk("rst_state", agc_state,   0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Unity pass-through with exact 3-cycle latency
        @(negedge clk);
        data_in = 12'sd500;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("uni_vld_n1", audio_valid, 0);
        @(negedge clk);
        chk("uni_vld_n2", audio_valid, 0);
        @(negedge clk);
        chk("uni_vld_n3", audio_valid, 1);
        chk("uni_out",    audio_out,   500);
        chk("uni_clip",   clip,        0);
        chk("uni_gain",   gain,        256);
        chk("uni_state0", agc_state,   0);
        @(negedge clk);
        chk("uni_state1", agc_state,   3);
        chk("uni_vld_n4", audio_valid, 0);
        push(-12'sd500, 1'b0);
        chk("uni_neg_vld",  audio_valid, 1);
        chk("uni_neg_out",  audio_out,   -500);
        chk("uni_neg_clip", clip,        0);

        // Overload attack: 256 - 256/8 = 224
        push(12'sd1800, 1'b0);
        chk("atk_out",  audio_out, 1800);
        chk("atk_clip", clip,      0);
        @(negedge clk);
        chk("atk_gain",  gain,      224);
        chk("atk_state", agc_state, 1);
        push(12'sd1000, 1'b0);
        chk("atk_out2", audio_out, 875);
        @(negedge clk);
        chk("atk_to_hold", agc_state, 2);
        chk("atk_gain2",   gain,      224);

        // Hold for 2048 samples, then +1 gain every 64 samples
        stream(2047, 12'sd100, 1'b0);
        chk("hold_state", agc_state, 2);
        chk("hold_out",   audio_out, 87);
        chk("hold_gain",  gain,      224);
        stream(1, 12'sd100, 1'b0);
        chk("hold_to_decay", agc_state, 3);
        stream(63, 12'sd100, 1'b0);
        chk("dec_gain_a", gain, 224);
        stream(1, 12'sd100, 1'b0);
        chk("dec_gain_b", gain, 225);
        stream(63, 12'sd100, 1'b0);
        chk("dec_gain_c", gain, 225);
        stream(1, 12'sd100, 1'b0);
        chk("dec_gain_d", gain, 226);
        chk("dec_state",  agc_state, 3);

        // Back-to-back then sparse valids: output pattern is the input pattern delayed 3
        data_in = 12'sd50;
        out_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            chk($sformatf("gap_vld%0d", i), audio_valid, (i >= 3) ? pat(i - 3) : 1'b0);
            if (audio_valid) out_cnt++;
            data_valid = pat(i);
        end
        data_valid = 1'b0;
        chk("gap_count", out_cnt, 16);

        // Reset one cycle after a sample enters
        @(negedge clk);
        chk("pre_rst_out", audio_out, 44);
        data_in = 12'sd300;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out",   audio_out,   0);
        chk("mid_rst_vld",   audio_valid, 0);
        chk("mid_rst_clip",  clip,        0);
        chk("mid_rst_gain",  gain,        256);
        chk("mid_rst_state", agc_state,   0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_vld%0d", i), audio_valid, 0);
        end
        chk("post_rst_gain",  gain,      256);
        chk("post_rst_state", agc_state, 0);

        // Decay up to the ceiling, then saturate both ways
        stream(5, 12'sd2, 1'b1);
        chk("hi_gain_a",  hi_gain,  4094);
        chk("hi_state_a", hi_state, 3);
        stream(4, 12'sd2, 1'b1);
        chk("hi_gain_max",  hi_gain,  4095);
        chk("hi_state_max", hi_state, 0);
        stream(5, 12'sd2, 1'b1);
        chk("hi_gain_ceil",  hi_gain,  4095);
        chk("hi_state_ceil", hi_state, 3);
        push(12'sd1000, 1'b1);
        chk("sat_pos_vld",  hi_audio_valid, 1);
        chk("sat_pos_out",  hi_out,         2047);
        chk("sat_pos_clip", hi_clip,        1);
        @(negedge clk);
        chk("sat_atk_gain",  hi_gain,  3584);
        chk("sat_atk_state", hi_state, 1);
        chk("sat_clip_low",  hi_clip,  0);
        push(-12'sd2048, 1'b1);
        chk("sat_neg_out",  hi_out,  -2048);
        chk("sat_neg_clip", hi_clip, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
